mem_wait_ctrl: RTL and testbench
================================

# mem_wait_ctrl

Memory-side slave that sits directly downstream of the CPU bus master and services its word read/write requests. Decodes the request address into a memory region, inserts a per-region number of wait states, drives a single synchronous backing-memory port, and returns read data plus a one-cycle completion pulse. Replaces the zero-latency memory model so the control unit sees real, region-dependent access latency.

## Interface
- BIOS_WAIT, 0, wait states for region 0x0 (BIOS, read-only)
- EWRAM_WAIT, 2, wait states for region 0x2
- IWRAM_WAIT, 0, wait states for region 0x3
- IO_WAIT, 0, wait states for region 0x4
- ROM_WAIT, 4, wait states for regions 0x8–0xD (ROM, read-only); every *_WAIT is legal only in 0..15
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- cpu_addr  in  32  byte address; bits [1:0] ignored (word access only)
- cpu_read_en  in  1  read request
- cpu_write_en  in  1  write request
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  registered read data, held until the next read completes
- cpu_ready  out  1  registered one-cycle completion pulse
- cpu_err  out  1  registered pulse coincident with cpu_ready for a failed or dropped request
- cpu_busy  out  1  high whenever state != IDLE
- mem_region  out  3  0=BIOS 1=EWRAM 2=IWRAM 3=IO 4=ROM; driven from the latched request
- mem_addr  out  22  word address, latched cpu_addr[23:2]
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  32  latched write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_re

## Operation
- States: IDLE, WAIT, ISSUE, CAPTURE.
- IDLE: accept on cpu_read_en | cpu_write_en. On the accepting edge, latch the address, write data, direction and decoded region, and load the 4-bit wait counter with the region's *_WAIT.
  - Next state is WAIT if the count is >0, else ISSUE.
  - Requests seen in any other state are ignored. The CPU holds its request until cpu_ready.
- WAIT: decrement the counter each cycle. Move to ISSUE on the edge where the counter is 1.
- ISSUE: for one cycle, assert mem_re (read) or mem_we (write), decoded from the state register. Then go to CAPTURE.
- CAPTURE: on a read, register mem_rdata into cpu_rdata. Register cpu_ready=1, then return to IDLE.
- Region decode uses cpu_addr[27:24]:
  - 0x0 → BIOS
  - 0x2 → EWRAM
  - 0x3 → IWRAM
  - 0x4 → IO
  - 0x8–0xD → ROM
  - all other values are unmapped.
- Unmapped request: 0 waits, no strobe in ISSUE. A read loads cpu_rdata=0. cpu_err pulses.
- Write to BIOS or ROM: counts the region's waits, but mem_we is suppressed in ISSUE and cpu_err pulses.
- cpu_read_en and cpu_write_en both high in IDLE: request rejected.
  - No latch or strobe occurs. The controller goes straight to CAPTURE next cycle without updating cpu_rdata.
  - cpu_ready and cpu_err pulse one cycle later.
- cpu_rdata is not changed by writes, errors, or rejections. The one exception is an unmapped read, which writes 0.

## Timing
- Reset values: state IDLE, cpu_rdata=0, cpu_ready=0, cpu_err=0, cpu_busy=0, mem_re=0, mem_we=0, mem_addr=0, mem_region=0, mem_wdata=0, counter=0.
- Cycle numbering for a valid request with N waits, request sampled in cycle 0:
  - WAIT occupies cycles 1..N.
  - ISSUE is cycle N+1.
  - CAPTURE is cycle N+2.
  - cpu_ready, cpu_err and the new cpu_rdata are visible in cycle N+3. Total latency is N+3.
- Rejected dual-enable request: CAPTURE in cycle 1, cpu_ready in cycle 2.
- Back-to-back requests: the ready cycle is IDLE, so a request present in the same cycle as cpu_ready is accepted. Minimum 3 cycles per access.
- cpu_busy is high in cycles 1..N+2, and low in cycle 0 and in the ready cycle.
- Reset mid-operation:
  - Takes effect at the next edge and returns all state to reset values. No cpu_ready is produced for the aborted request.
  - A strobe already asserted in the cycle reset is sampled still reaches memory, because strobes are decoded from the pre-reset state.

## Test plan
- IWRAM read at 0x0300_0010, mem_rdata=0xDEAD_BEEF in CAPTURE → mem_re in cycle 1, mem_addr=0x4, cpu_ready in cycle 3, cpu_rdata=0xDEAD_BEEF, cpu_err=0.
- EWRAM write of 0x1234_5678 to 0x0200_0004, then a read of the same address (wait=2) → mem_we in cycle 3, ready in cycle 5, read ready 5 cycles after acceptance returns 0x1234_5678.
- ROM read at 0x0800_0000 (wait=4) → cpu_busy in cycles 1–6, mem_re in cycle 5, ready in cycle 7. A ROM write to the same address gives no mem_we, and cpu_err=1 with ready in cycle 7.
- Unmapped read at 0x0100_0000 → no strobe, ready in cycle 3 with cpu_rdata=0 and cpu_err=1. Dual-enable request → ready and err in cycle 2, cpu_rdata unchanged.
- Back-to-back IWRAM reads held continuously → ready pulses in cycles 3, 6, 9 with no lost or duplicated access.
- EWRAM read with reset asserted in cycle 2 → state IDLE, no mem_re, no cpu_ready. All outputs are at reset values in cycle 3, and the next request completes normally.

Source files
------------

// File: rtl/mem_wait_ctrl.sv
// ============================================================================
// Module   : mem_wait_ctrl
// Purpose  : CPU-bus memory slave with region decode and per-region wait states
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_ctrl #(
  parameter int unsigned BIOS_WAIT  = 0,
  parameter int unsigned EWRAM_WAIT = 2,
  parameter int unsigned IWRAM_WAIT = 0,
  parameter int unsigned IO_WAIT    = 0,
  parameter int unsigned ROM_WAIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_cpu_addr,
  input  logic        i_cpu_read_en,
  input  logic        i_cpu_write_en,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_ready,
  output logic        o_cpu_err,
  output logic        o_cpu_busy,
  output logic [2:0]  o_mem_region,
  output logic [21:0] o_mem_addr,
  output logic        o_mem_re,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ISSUE   = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam logic [2:0] c_REG_BIOS  = 3'd0;
  localparam logic [2:0] c_REG_EWRAM = 3'd1;
  localparam logic [2:0] c_REG_IWRAM = 3'd2;
  localparam logic [2:0] c_REG_IO    = 3'd3;
  localparam logic [2:0] c_REG_ROM   = 3'd4;
  localparam logic [2:0] c_REG_NONE  = 3'd7;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_is_read;
  logic        r_strobe_ok;
  logic        r_err_pend;
  logic        r_rd_load;
  logic        r_rd_zero;
  logic [31:0] r_cpu_rdata;
  logic        r_cpu_ready;
  logic        r_cpu_err;
  logic [2:0]  r_region;
  logic [21:0] r_addr;
  logic [31:0] r_wdata;

  logic [2:0]  w_region;
  logic [3:0]  w_wait;
  logic        w_mapped;
  logic        w_ro;
  logic        w_req;
  logic        w_dual;
  logic        w_unused;

  assign w_unused = ^{i_cpu_addr[31:28], i_cpu_addr[1:0]};
  assign w_req    = i_cpu_read_en | i_cpu_write_en;
  assign w_dual   = i_cpu_read_en & i_cpu_write_en;

  always_comb begin
    w_region = c_REG_NONE;
    w_wait   = 4'd0;
    w_mapped = 1'b1;
    w_ro     = 1'b0;
    case (i_cpu_addr[27:24])
      4'h0: begin w_region = c_REG_BIOS;  w_wait = 4'(BIOS_WAIT);  w_ro = 1'b1; end
      4'h2: begin w_region = c_REG_EWRAM; w_wait = 4'(EWRAM_WAIT); end
      4'h3: begin w_region = c_REG_IWRAM; w_wait = 4'(IWRAM_WAIT); end
      4'h4: begin w_region = c_REG_IO;    w_wait = 4'(IO_WAIT);    end
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
        w_region = c_REG_ROM;
        w_wait   = 4'(ROM_WAIT);
        w_ro     = 1'b1;
      end
      default: w_mapped = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dual)
          w_state_nxt = S_CAPTURE;
        else if (w_req)
          w_state_nxt = (w_wait != 4'd0) ? S_WAIT : S_ISSUE;
      end
      S_WAIT:    if (r_cnt == 4'd1) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_is_read   <= 1'b0;
      r_strobe_ok <= 1'b0;
      r_err_pend  <= 1'b0;
      r_rd_load   <= 1'b0;
      r_rd_zero   <= 1'b0;
      r_cpu_rdata <= 32'd0;
      r_cpu_ready <= 1'b0;
      r_cpu_err   <= 1'b0;
      r_region    <= 3'd0;
      r_addr      <= 22'd0;
      r_wdata     <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_ready <= 1'b0;
      r_cpu_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_dual) begin
            // Rejected request: leave address/data latches untouched
            r_err_pend  <= 1'b1;
            r_rd_load   <= 1'b0;
            r_rd_zero   <= 1'b0;
            r_strobe_ok <= 1'b0;
          end else if (w_req) begin
            r_region    <= w_region;
            r_addr      <= i_cpu_addr[23:2];
            r_wdata     <= i_cpu_wdata;
            r_cnt       <= w_wait;
            r_is_read   <= i_cpu_read_en;
            r_strobe_ok <= w_mapped & (i_cpu_read_en | ~w_ro);
            r_err_pend  <= ~w_mapped | (i_cpu_write_en & w_ro);
            r_rd_load   <= i_cpu_read_en;
            r_rd_zero   <= ~w_mapped;
          end
        end
        S_WAIT: r_cnt <= r_cnt - 4'd1;
        S_CAPTURE: begin
          r_cpu_ready <= 1'b1;
          r_cpu_err   <= r_err_pend;
          if (r_rd_load)
            r_cpu_rdata <= r_rd_zero ? 32'd0 : i_mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode the current state so an in-flight strobe survives a reset edge
  assign o_mem_re     = (r_state == S_ISSUE) & r_strobe_ok & r_is_read;
  assign o_mem_we     = (r_state == S_ISSUE) & r_strobe_ok & ~r_is_read;
  assign o_cpu_busy   = (r_state != S_IDLE);
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_cpu_ready  = r_cpu_ready;
  assign o_cpu_err    = r_cpu_err;
  assign o_mem_region = r_region;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_wait_ctrl.sv
// ============================================================================
// Module   : tb_mem_wait_ctrl
// Purpose  : Self-checking bench for mem_wait_ctrl with directed and random traffic
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wait_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        ready;
  logic        err;
  logic        busy;
  logic [2:0]  mem_region;
  logic [21:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] bmem [bit [24:0]];
  logic [31:0] rmem [bit [24:0]];
  logic [3:0]  nib_tab [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'hD, 4'hF};

  mem_wait_ctrl #(
    .BIOS_WAIT(0), .EWRAM_WAIT(2), .IWRAM_WAIT(0), .IO_WAIT(0), .ROM_WAIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .i_cpu_addr(cpu_addr), .i_cpu_read_en(cpu_rd), .i_cpu_write_en(cpu_wr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_ready(ready),
    .o_cpu_err(err), .o_cpu_busy(busy), .o_mem_region(mem_region),
    .o_mem_addr(mem_addr), .o_mem_re(mem_re), .o_mem_we(mem_we),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous backing memory: data valid the cycle after mem_re
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= bmem.exists({mem_region, mem_addr}) ? bmem[{mem_region, mem_addr}] : 32'd0;
    if (mem_we) bmem[{mem_region, mem_addr}] = mem_wdata;
  end

  function automatic int region_of(input logic [31:0] a);
    case (a[27:24])
      4'h0: return 0;
      4'h2: return 1;
      4'h3: return 2;
      4'h4: return 3;
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic int wait_of(input int r);
    case (r)
      1: return 2;
      4: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ro_of(input int r);
    return (r == 0) || (r == 4);
  endfunction

  task automatic idle(input int n);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Holds one request until ready (or budget) and records what the DUT did
  task automatic run_req(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                         output int rdy_c, output logic e, output logic [31:0] rdat,
                         output int re_n, output int we_n, output int strb_c,
                         output logic [21:0] strb_a, output logic [63:0] busy_v);
    rdy_c = -1; e = 1'b0; rdat = 32'd0; re_n = 0; we_n = 0; strb_c = -1; strb_a = 22'd0; busy_v = 64'd0;
    cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_wdata = wd;
    for (int c = 0; c < 40; c++) begin
      busy_v[c] = busy;
      if (c > 0) begin
        if (mem_re) begin re_n++; strb_c = c; strb_a = mem_addr; end
        if (mem_we) begin we_n++; strb_c = c; strb_a = mem_addr; end
        if (ready) begin rdy_c = c; e = err; rdat = cpu_rdata; break; end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++; if (cpu_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({mem_re, mem_we} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_re, mem_we}); end
    checks++; if ({mem_region, mem_addr, mem_wdata} !== 57'd0) begin failures++;
      $display("FAIL reset_mem_outs got=%h/%h/%h exp=0", mem_region, mem_addr, mem_wdata); end
  endtask

  task automatic test_iwram_read();
    int rc, rn, wn, sc; logic e; logic [31:0] rd; logic [21:0] sa; logic [63:0] bv;
    bmem[{3'd2, 22'h4}] = 32'hDEAD_BEEF;
    run_req(32'h0300_0010, 1'b1, 1'b0, 32'd0, rc, e, rd, rn, wn, sc, sa, bv);
    checks++; if (rn !== 1 || sc !== 1) begin failures++; $display("FAIL iwram_re got=%0d@%0d exp=1@1", rn, sc); end
    checks++; if (sa !== 22'h4) begin failures++; $display("FAIL iwram_addr got=%h exp=4", sa); end
    checks++; if (rc !== 3) begin failures++; $display("FAIL iwram_ready_cycle got=%0d exp=3", rc); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL iwram_rdata got=%h exp=deadbeef", rd); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL iwram_err got=%b exp=0", e); end
    checks++; if (bv !== 64'h6) begin failures++; $display("FAIL iwram_busy got=%h exp=6", bv); end
    idle(1);
    checks++; if ({ready, err} !== 2'b00) begin failures++; $display("FAIL ready_pulse_width got=%b exp=00", {ready, err}); end
  endtask

  task automatic test_ewram_write_read();
    int rc, rn, wn, sc; logic e; logic [31:0] rd; logic [21:0] sa; logic [63:0] bv;
    run_req(32'h0200_0004, 1'b0, 1'b1, 32'h1234_5678, rc, e, rd, rn, wn, sc, sa, bv);
    idle(1);
    checks++; if (wn !== 1 || sc !== 3 || rn !== 0) begin failures++; $display("FAIL ewram_we got=%0d@%0d re=%0d exp=1@3 re=0", wn, sc, rn); end
    checks++; if (rc !== 5 || e !== 1'b0) begin failures++; $display("FAIL ewram_wr_ready got=%0d err=%b exp=5 err=0", rc, e); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ewram_wr_rdata_hold got=%h exp=deadbeef", rd); end
    run_req(32'h0200_0004, 1'b1, 1'b0, 32'd0, rc, e, rd, rn, wn, sc, sa, bv);
    idle(1);
    checks++; if (rn !== 1 || sc !== 3) begin failures++; $display("FAIL ewram_re got=%0d@%0d exp=1@3", rn, sc); end
    checks++; if (rc !== 5 || rd !== 32'h1234_5678) begin failures++; $display("FAIL ewram_rd got=%0d/%h exp=5/12345678", rc, rd); end
  endtask

  task automatic test_rom();
    int rc, rn, wn, sc; logic e; logic [31:0] rd; logic [21:0] sa; logic [63:0] bv;
    bmem[{3'd4, 22'h0}] = 32'hA5A5_0001;
    run_req(32'h0800_0000, 1'b1, 1'b0, 32'd0, rc, e, rd, rn, wn, sc, sa, bv);
    idle(1);
    checks++; if (bv !== 64'h7E) begin failures++; $display("FAIL rom_busy got=%h exp=7e", bv); end
    checks++; if (rn !== 1 || sc !== 5) begin failures++; $display("FAIL rom_re got=%0d@%0d exp=1@5", rn, sc); end
    checks++; if (rc !== 7 || rd !== 32'hA5A5_0001 || e !== 1'b0) begin failures++;
      $display("FAIL rom_rd got=%0d/%h/%b exp=7/a5a50001/0", rc, rd, e); end
    run_req(32'h0800_0000, 1'b0, 1'b1, 32'hFFFF_0000, rc, e, rd, rn, wn, sc, sa, bv);
    idle(1);
    checks++; if (wn !== 0 || rn !== 0) begin failures++; $display("FAIL rom_wr_strobe got=we%0d re%0d exp=0", wn, rn); end
    checks++; if (rc !== 7 || e !== 1'b1) begin failures++; $display("FAIL rom_wr_ready got=%0d err=%b exp=7 err=1", rc, e); end
    checks++; if (rd !== 32'hA5A5_0001) begin failures++; $display("FAIL rom_wr_rdata got=%h exp=a5a50001", rd); end
  endtask

  task automatic test_unmapped_dual();
    int rc, rn, wn, sc; logic e; logic [31:0] rd; logic [21:0] sa; logic [63:0] bv;
    run_req(32'h0300_0010, 1'b1, 1'b1, 32'h5555_5555, rc, e, rd, rn, wn, sc, sa, bv);
    idle(1);
    checks++; if (rc !== 2 || e !== 1'b1) begin failures++; $display("FAIL dual_ready got=%0d err=%b exp=2 err=1", rc, e); end
    checks++; if (rn !== 0 || wn !== 0) begin failures++; $display("FAIL dual_strobe got=re%0d we%0d exp=0", rn, wn); end
    checks++; if (rd !== 32'hA5A5_0001) begin failures++; $display("FAIL dual_rdata got=%h exp=a5a50001", rd); end
    checks++; if (mem_wdata !== 32'hFFFF_0000) begin failures++; $display("FAIL dual_no_latch got=%h exp=ffff0000", mem_wdata); end
    run_req(32'h0100_0000, 1'b1, 1'b0, 32'd0, rc, e, rd, rn, wn, sc, sa, bv);
    idle(1);
    checks++; if (rn !== 0 || wn !== 0) begin failures++; $display("FAIL unmapped_strobe got=re%0d we%0d exp=0", rn, wn); end
    checks++; if (rc !== 3 || e !== 1'b1 || rd !== 32'd0) begin failures++;
      $display("FAIL unmapped_rd got=%0d/%b/%h exp=3/1/0", rc, e, rd); end
  endtask

  task automatic test_back_to_back();
    int rc, rn, wn, sc, tot; logic e; logic [31:0] rd; logic [21:0] sa; logic [63:0] bv;
    tot = 0;
    for (int i = 0; i < 3; i++) bmem[{3'd2, 22'(32'h10 + i)}] = 32'hB0B0_0000 + i;
    for (int i = 0; i < 3; i++) begin
      run_req(32'h0300_0040 + 32'(i * 4), 1'b1, 1'b0, 32'd0, rc, e, rd, rn, wn, sc, sa, bv);
      tot += rc;
      checks++; if (tot !== 3 * (i + 1) || rn !== 1) begin failures++;
        $display("FAIL b2b_ready[%0d] got=%0d re=%0d exp=%0d re=1", i, tot, rn, 3 * (i + 1)); end
      checks++; if (rd !== 32'hB0B0_0000 + i) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, rd, 32'hB0B0_0000 + i); end
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    int rc, rn, wn, sc, saw_re, saw_rdy; logic e; logic [31:0] rd; logic [21:0] sa; logic [63:0] bv;
    saw_re = 0; saw_rdy = 0;
    cpu_addr = 32'h0200_0008; cpu_rd = 1'b1; cpu_wr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin saw_re += int'(mem_re); saw_rdy += int'(ready); end
      if (c == 2) reset = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b0; cpu_rd = 1'b0;
    saw_re += int'(mem_re); saw_rdy += int'(ready);
    checks++; if (saw_re !== 0 || saw_rdy !== 0) begin failures++; $display("FAIL rst_mid_activity got=re%0d rdy%0d exp=0", saw_re, saw_rdy); end
    checks++; if ({busy, err, mem_we} !== 3'b000 || cpu_rdata !== 32'd0) begin failures++;
      $display("FAIL rst_mid_state got=busy%b err%b rdata=%h exp=0", busy, err, cpu_rdata); end
    checks++; if ({mem_region, mem_addr, mem_wdata} !== 57'd0) begin failures++;
      $display("FAIL rst_mid_mem_outs got=%h/%h/%h exp=0", mem_region, mem_addr, mem_wdata); end
    run_req(32'h0200_0004, 1'b1, 1'b0, 32'd0, rc, e, rd, rn, wn, sc, sa, bv);
    idle(1);
    checks++; if (rc !== 5 || rd !== 32'h1234_5678 || e !== 1'b0) begin failures++;
      $display("FAIL rst_mid_next got=%0d/%h/%b exp=5/12345678/0", rc, rd, e); end
  endtask

  task automatic test_random();
    int rc, rn, wn, sc, r, lat, exp_re, exp_we; logic e, exp_e, rd, wr; logic [31:0] a, wd, rdat, exp_rd;
    logic [21:0] sa; logic [63:0] bv; logic [24:0] k; logic [3:0] nib;
    bmem.delete(); rmem.delete();
    reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; exp_rd = 32'd0;
    for (int i = 0; i < 40; i++) begin
      nib = nib_tab[$urandom_range(0, 8)];
      a = $urandom(); a[27:24] = nib; a[22:5] = '0;
      wd = $urandom();
      if ($urandom_range(0, 9) == 0) begin rd = 1'b1; wr = 1'b1; end
      else begin rd = 1'($urandom_range(0, 1)); wr = ~rd; end
      r = region_of(a);
      k = {3'(r), a[23:2]};
      exp_re = 0; exp_we = 0; exp_e = 1'b0;
      if (rd && wr) begin lat = 2; exp_e = 1'b1; end
      else if (r < 0) begin lat = 3; exp_e = 1'b1; if (rd) exp_rd = 32'd0; end
      else begin
        lat = wait_of(r) + 3;
        if (rd) begin exp_re = 1; exp_rd = rmem.exists(k) ? rmem[k] : 32'd0; end
        else if (ro_of(r)) exp_e = 1'b1;
        else begin exp_we = 1; rmem[k] = wd; end
      end
      run_req(a, rd, wr, wd, rc, e, rdat, rn, wn, sc, sa, bv);
      checks++; if (rc !== lat) begin failures++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d addr=%h", i, rc, lat, a); end
      checks++; if (e !== exp_e) begin failures++; $display("FAIL rnd_err[%0d] got=%b exp=%b addr=%h", i, e, exp_e, a); end
      checks++; if (rdat !== exp_rd) begin failures++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h addr=%h", i, rdat, exp_rd, a); end
      checks++; if (rn !== exp_re) begin failures++; $display("FAIL rnd_re[%0d] got=%0d exp=%0d", i, rn, exp_re); end
      checks++; if (wn !== exp_we) begin failures++; $display("FAIL rnd_we[%0d] got=%0d exp=%0d", i, wn, exp_we); end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cpu_addr = 32'd0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    idle(1);
    test_iwram_read();
    test_ewram_write_read();
    test_rom();
    test_unmapped_dual();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
